// File: rtl/axis_pkg.sv
// Shared definitions for the accelerator's AXI-Stream blocks (axis_master and
// axis_slave): the framer state type, default widths, and a helper for sizing
// counters.
package axis_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } axis_state_t;

  localparam int AXIS_TDATA_WIDTH = 32;
  localparam int AXIS_FIFO_DEPTH  = 16;
  localparam int AXIS_FRAME_LEN   = 10;

  // $clog2 returns 0 for n == 1. A zero-width vector is illegal, so the
  // counter always keeps at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_master_if.sv
// AXI-Stream bus bundle between the accelerator's output master and the DMA.
//   M_AXIS_TVALID  beat valid        (master -> slave)
//   M_AXIS_TDATA   beat payload      (master -> slave)
//   M_AXIS_TSTRB   byte strobes      (master -> slave)
//   M_AXIS_TLAST   last beat of frame(master -> slave)
//   M_AXIS_TREADY  sink ready        (slave -> master)
interface axis_master_if
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH
);

  logic                     M_AXIS_TVALID;
  logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA;
  logic [TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
  logic                     M_AXIS_TLAST;
  logic                     M_AXIS_TREADY;

  modport master (
    output M_AXIS_TVALID,
    output M_AXIS_TDATA,
    output M_AXIS_TSTRB,
    output M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TVALID,
    input  M_AXIS_TDATA,
    input  M_AXIS_TSTRB,
    input  M_AXIS_TLAST,
    output M_AXIS_TREADY
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue output.
//   clk, rst   clock; asynchronous active-high reset
//   push       write request (ignored while full)
//   push_data  word to write
//   pop        consume the head word (ignored while empty)
//   full       occupancy == DEPTH
//   empty      occupancy == 0
//   count      registered occupancy
//   head       registered copy of the oldest word; valid whenever !empty
// The head register always tracks the front entry, so a consumer can use it
// directly as an output register and the occupancy counts that entry too.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DATA_WIDTH-1:0]        head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] head_reg;
  logic [DATA_WIDTH-1:0] head_next;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign head    = head_reg;

  // Full is registered, so a pop in the same cycle does not free a slot.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Head update: an incoming word bypasses storage when it becomes the front
  // immediately (empty queue, or the only entry is leaving); otherwise a pop
  // fetches the next stored entry, which is always already written.
  always_comb begin
    head_next = head_reg;
    if (do_push && (empty || (do_pop && count_reg == CNT_W'(1)))) begin
      head_next = push_data;
    end else if (do_pop && count_reg > CNT_W'(1)) begin
      head_next = mem[rd_ptr_reg + PTR_W'(1)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end

endmodule

// File: rtl/axis_master.sv
// Output AXI-Stream master of the MLP accelerator. Buffers result words from
// the MLP core and streams them to the DMA in frames of FRAME_LEN beats,
// marking the final beat of each frame with TLAST.
//   M_AXIS_ACLK        clock
//   M_AXIS_ARESET      asynchronous active-high reset
//   pi_mlp_data        result word from the core
//   pi_mlp_data_valid  result word valid
//   po_mlp_data_ready  buffer can take a word (from registered occupancy only)
//   po_overflow        sticky: a word arrived while full and was dropped
//   po_busy            a frame is partially transmitted
//   m_axis             AXI-Stream master bus (TVALID/TDATA/TSTRB/TLAST/TREADY)
// The FIFO head register doubles as the AXIS output register: TDATA is that
// register, and TVALID/TSTRB/TLAST are decoded from registered state only.
module axis_master
  import axis_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH,
  parameter int FIFO_DEPTH           = AXIS_FIFO_DEPTH,
  parameter int FRAME_LEN            = AXIS_FRAME_LEN
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] pi_mlp_data,
  input  logic                            pi_mlp_data_valid,
  output logic                            po_mlp_data_ready,
  output logic                            po_overflow,
  output logic                            po_busy,
  axis_master_if.master                   m_axis
);

  localparam int                CNT_W      = cnt_width(FRAME_LEN);
  localparam int                FIFO_CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int                STRB_W     = C_M_AXIS_TDATA_WIDTH / 8;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(FRAME_LEN - 1);

  logic                            fifo_full;
  logic                            fifo_empty;
  logic [FIFO_CNT_W-1:0]           fifo_count;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_head;
  logic                            xfer;
  logic                            beat_last;
  logic [CNT_W-1:0]                beat_cnt_reg;
  logic [CNT_W-1:0]                beat_cnt_next;
  axis_state_t                     state_reg;
  axis_state_t                     state_next;
  logic                            overflow_reg;

  sync_fifo #(
    .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (M_AXIS_ACLK),
    .rst       (M_AXIS_ARESET),
    .push      (pi_mlp_data_valid),
    .push_data (pi_mlp_data),
    .pop       (xfer),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign po_mlp_data_ready    = (fifo_count != FIFO_CNT_W'(FIFO_DEPTH));
  assign po_overflow          = overflow_reg;
  assign po_busy              = (state_reg == STREAM);

  assign beat_last            = (beat_cnt_reg == LAST_BEAT);
  assign xfer                 = ~fifo_empty & m_axis.M_AXIS_TREADY;

  assign m_axis.M_AXIS_TVALID = ~fifo_empty;
  assign m_axis.M_AXIS_TDATA  = fifo_head;
  assign m_axis.M_AXIS_TLAST  = ~fifo_empty & beat_last;

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
    assign m_axis.M_AXIS_TSTRB[gi] = ~fifo_empty;
  end

  // Beat counter and framer. For FRAME_LEN == 1 every beat is last, so the
  // framer never leaves IDLE.
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    if (xfer) begin
      beat_cnt_next = beat_last ? '0 : beat_cnt_reg + CNT_W'(1);
      case (state_reg)
        IDLE:    if (!beat_last) state_next = STREAM;
        STREAM:  if (beat_last)  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      if (pi_mlp_data_valid && fifo_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_master.sv
// Bench for axis_master: directed scenarios plus a random-handshake run.
// Stimulus is driven just after the rising edge; a monitor samples on the
// falling edge, compares against a reference occupancy model and an expected
// beat queue, then advances the model for the coming edge.
module tb_axis_master;
  import axis_pkg::*;

  localparam int TDW   = 32;
  localparam int DEPTH = 16;
  localparam int FLEN  = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [TDW-1:0] drv_data = '0;
  logic           drv_valid = 1'b0;
  logic           drv_ready = 1'b0;
  logic           ready;
  logic           ovf;
  logic           busy;

  always #5 clk = ~clk;

  axis_master_if #(.TDATA_WIDTH(TDW)) m_axis ();
  assign m_axis.M_AXIS_TREADY = drv_ready;

  axis_master #(
    .C_M_AXIS_TDATA_WIDTH (TDW),
    .FIFO_DEPTH           (DEPTH),
    .FRAME_LEN            (FLEN)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESET     (rst),
    .pi_mlp_data       (drv_data),
    .pi_mlp_data_valid (drv_valid),
    .po_mlp_data_ready (ready),
    .po_overflow       (ovf),
    .po_busy           (busy),
    .m_axis            (m_axis)
  );

  typedef struct packed {
    logic [TDW-1:0] data;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int    model_occ = 0;
  int    in_idx    = 0;
  int    out_idx   = 0;
  bit    model_ovf = 1'b0;
  int    checks    = 0;
  int    passes    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    forever begin
      bit    acc;
      bit    pop;
      beat_t hd;
      @(negedge clk);
      if (rst) begin
        check("rst_tvalid", 32'(m_axis.M_AXIS_TVALID), 32'd0);
        check("rst_tdata",  m_axis.M_AXIS_TDATA,       32'd0);
        check("rst_tstrb",  32'(m_axis.M_AXIS_TSTRB),  32'd0);
        check("rst_tlast",  32'(m_axis.M_AXIS_TLAST),  32'd0);
        check("rst_ovf",    32'(ovf),                  32'd0);
        check("rst_busy",   32'(busy),                 32'd0);
        check("rst_ready",  32'(ready),                32'd1);
        exp_q.delete();
        model_occ = 0;
        in_idx    = 0;
        out_idx   = 0;
        model_ovf = 1'b0;
      end else begin
        check("ready",    32'(ready),                 32'(model_occ != DEPTH));
        check("tvalid",   32'(m_axis.M_AXIS_TVALID),  32'(model_occ != 0));
        check("tstrb",    32'(m_axis.M_AXIS_TSTRB),   (model_occ != 0) ? 32'hF : 32'h0);
        check("overflow", 32'(ovf),                   32'(model_ovf));
        check("busy",     32'(busy),                  32'(out_idx != 0));
        if (model_occ != 0 && exp_q.size() > 0) begin
          hd = exp_q[0];
          check("tdata", m_axis.M_AXIS_TDATA,       hd.data);
          check("tlast", 32'(m_axis.M_AXIS_TLAST),  32'(hd.last));
        end
        pop = (model_occ != 0) && drv_ready;
        acc = drv_valid && (model_occ != DEPTH);
        if (drv_valid && model_occ == DEPTH) model_ovf = 1'b1;
        if (pop && exp_q.size() > 0) begin
          hd = exp_q.pop_front();
          $display("beat %0d data=0x%0h last=%0d", out_idx, hd.data, hd.last);
          out_idx = hd.last ? 0 : out_idx + 1;
        end
        if (acc) begin
          exp_q.push_back('{data: drv_data, last: (in_idx == FLEN-1)});
          in_idx = (in_idx == FLEN-1) ? 0 : in_idx + 1;
        end
        if (acc) model_occ++;
        if (pop) model_occ--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [TDW-1:0] d);
    drv_data  = d;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
  endtask

  task automatic do_reset();
    drv_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles, input string tag);
    int n;
    n = 0;
    drv_ready = 1'b1;
    while (model_occ != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(model_occ), 32'd0);
    tick();
  endtask

  initial begin : stimulus
    int sent;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: ten words with TREADY high -> one frame, TLAST on 0xA
    drv_ready = 1'b1;
    for (int i = 1; i <= 10; i++) push_word(TDW'(i));
    drain(20, "s1");
    check("s1_busy_after", 32'(busy), 32'd0);

    // 2: three words held under backpressure for five cycles
    drv_ready = 1'b0;
    for (int i = 1; i <= 3; i++) push_word(TDW'(i));
    repeat (5) tick();
    check("s2_stall_tdata", m_axis.M_AXIS_TDATA, 32'h1);
    drain(20, "s2");

    // 3: seventeen words into a stalled sink -> last one dropped
    drv_ready = 1'b0;
    for (int i = 1; i <= 17; i++) push_word(32'h100 + TDW'(i));
    check("s3_overflow", 32'(ovf),   32'd1);
    check("s3_ready",    32'(ready), 32'd0);
    drain(40, "s3");
    do_reset();

    // 4: 25 words streamed through -> frame counter ends mid-frame at 5
    drv_ready = 1'b1;
    for (int i = 0; i < 25; i++) push_word(32'h200 + TDW'(i));
    drain(20, "s4");
    check("s4_busy_mid", 32'(busy), 32'd1);
    check("s4_no_ovf",   32'(ovf),  32'd0);

    // 5: reset after beat 4 of a fresh frame, with words still buffered
    do_reset();
    drv_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'h300 + TDW'(i));
    drain(20, "s5a");
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h310 + TDW'(i));
    do_reset();
    check("s5_tvalid_after_rst", 32'(m_axis.M_AXIS_TVALID), 32'd0);
    check("s5_busy_after_rst",   32'(busy),                 32'd0);
    drv_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_word(32'h320 + TDW'(i));
    drain(20, "s5b");
    check("s5_busy_frame_done", 32'(busy), 32'd0);

    // 6: random valid and ready over 200 words
    sent = 0;
    while (sent < 200) begin
      drv_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        push_word(32'h1000 + TDW'(sent));
        sent++;
      end else begin
        tick();
      end
    end
    drain(200, "s6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
